sysbus_uart_tx: RTL

SYSBUS_UART_TX -- requirements
Module: sysbus_uart_tx

---
 rtl/sysbus_uart_tx.sv | 201 ++++++++++++++++++++
 1 files changed

// File: rtl/sysbus_uart_tx.sv
// sysbus_uart_tx: 6809 bus-attached UART transmitter with a transmit FIFO,
// programmable baud divisor, CTS flow control and a registered interrupt.
// All state advances on the falling edge of ECLK (end of the bus cycle).
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | line idle (TXD=1), waiting for TXEN, data and clear-to-send
// START | start bit (TXD=0) for one bit time
// DATA  | 8 data bits, LSB first, TXD = shift[0]
// STOP  | stop bit (TXD=1); at its end chain the next frame or go idle
module sysbus_uart_tx #(
  parameter int         FIFO_DEPTH = 8,
  parameter logic [7:0] BAUD_RESET = 8'h67
) (
  input  logic       ECLK,
  input  logic       RESET_B,
  input  logic       CSUART_B,
  input  logic [1:0] A,
  input  logic       WR_B,
  input  logic [7:0] D_IN,
  output logic [7:0] D_OUT,
  output logic       D_OE,
  output logic       IRQ_B,
  input  logic       CTS_B,
  output logic       TXD
);

  localparam int         PW      = $clog2(FIFO_DEPTH);
  localparam logic [4:0] DEPTH_C = 5'(FIFO_DEPTH);

  typedef enum logic [1:0] {ST_IDLE, ST_START, ST_DATA, ST_STOP} state_t;

  state_t        state, state_nxt;
  logic [7:0]    mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [4:0]    count;
  logic          ovr;
  logic [2:0]    ctrl;
  logic [7:0]    baud;
  logic [7:0]    baud_cnt;
  logic [2:0]    bit_cnt;
  logic [7:0]    shift;
  logic          irq_q;

  logic bus_wr, wr_data, wr_status, wr_ctrl, wr_baud;
  logic full, empty, txe, irq, tx_go, bit_end;
  logic pop, load_bit, shift_en, push_ok, ovr_set;

  // Bus write decode; reads never change state.
  always_comb begin
    bus_wr    = !CSUART_B && !WR_B;
    wr_data   = bus_wr && (A == 2'd0);
    wr_status = bus_wr && (A == 2'd1);
    wr_ctrl   = bus_wr && (A == 2'd2);
    wr_baud   = bus_wr && (A == 2'd3);
  end

  // Status flags and the start condition shared by IDLE and STOP end.
  always_comb begin
    full    = (count == DEPTH_C);
    empty   = (count == 5'd0);
    txe     = empty && (state == ST_IDLE);
    irq     = ctrl[1] && (txe || ovr);
    tx_go   = ctrl[0] && !empty && (!ctrl[2] || !CTS_B);
    bit_end = (baud_cnt == 8'd0);
    // FULL is judged before the pop, so a push racing a pop still fits.
    push_ok = wr_data && (!full || pop);
    ovr_set = wr_data && full && !pop;
  end

  // Next-state logic; load_bit reloads the bit timer at every bit boundary.
  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    load_bit  = 1'b0;
    shift_en  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (tx_go) begin
          state_nxt = ST_START;
          pop       = 1'b1;
          load_bit  = 1'b1;
        end
      end
      ST_START: begin
        if (bit_end) begin
          state_nxt = ST_DATA;
          load_bit  = 1'b1;
        end
      end
      ST_DATA: begin
        if (bit_end) begin
          load_bit = 1'b1;
          shift_en = 1'b1;
          if (bit_cnt == 3'd7) state_nxt = ST_STOP;
        end
      end
      ST_STOP: begin
        if (bit_end) begin
          if (tx_go) begin
            state_nxt = ST_START;
            pop       = 1'b1;
            load_bit  = 1'b1;
          end else begin
            state_nxt = ST_IDLE;
          end
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(negedge ECLK or negedge RESET_B) begin
    if (!RESET_B) state <= ST_IDLE;
    else          state <= state_nxt;
  end

  // Bit timer, bit counter and shift register; BAUD is sampled only on reload.
  always_ff @(negedge ECLK or negedge RESET_B) begin
    if (!RESET_B) begin
      baud_cnt <= 8'd0;
      bit_cnt  <= 3'd0;
      shift    <= 8'd0;
    end else begin
      if (load_bit)
        baud_cnt <= baud;
      else if (state != ST_IDLE && !bit_end)
        baud_cnt <= baud_cnt - 8'd1;
      if (pop) begin
        shift   <= mem[rd_ptr];
        bit_cnt <= 3'd0;
      end else if (shift_en) begin
        shift   <= {1'b0, shift[7:1]};
        bit_cnt <= bit_cnt + 3'd1;
      end
    end
  end

  // FIFO storage; contents are don't-care while COUNT says empty.
  always_ff @(negedge ECLK) begin
    if (push_ok) mem[wr_ptr] <= D_IN;
  end

  // FIFO pointers, occupancy and sticky overrun.
  always_ff @(negedge ECLK or negedge RESET_B) begin
    if (!RESET_B) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= 5'd0;
      ovr    <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop})
        2'b10:   count <= count + 5'd1;
        2'b01:   count <= count - 5'd1;
        default: count <= count;
      endcase
      if (ovr_set)
        ovr <= 1'b1;
      else if (wr_status && D_IN[2])
        ovr <= 1'b0;
    end
  end

  // CTRL and BAUD configuration registers.
  always_ff @(negedge ECLK or negedge RESET_B) begin
    if (!RESET_B) begin
      ctrl <= 3'd0;
      baud <= BAUD_RESET;
    end else begin
      if (wr_ctrl) ctrl <= D_IN[2:0];
      if (wr_baud) baud <= D_IN;
    end
  end

  // Interrupt flop: follows the cause one ECLK fall later.
  always_ff @(negedge ECLK or negedge RESET_B) begin
    if (!RESET_B) irq_q <= 1'b0;
    else          irq_q <= irq;
  end

  // Read mux, bus drive enable, IRQ and serial line outputs.
  always_comb begin
    case (A)
      2'd0:    D_OUT = 8'h00;
      2'd1:    D_OUT = {count[3:0], irq, ovr, full, txe};
      2'd2:    D_OUT = {5'd0, ctrl};
      default: D_OUT = baud;
    endcase
    D_OE  = !CSUART_B && WR_B;
    IRQ_B = !irq_q;
    case (state)
      ST_START: TXD = 1'b0;
      ST_DATA:  TXD = shift[0];
      default:  TXD = 1'b1;
    endcase
  end

endmodule
